// File: rtl/tc_mul_scheduler.sv
// Purpose: NREQ requesters share one signed 15x16 multiplier; each result carries its owner's id and tag.
// Latency: 2 cycles from acceptance to res_valid; one result per cycle sustained.
// Backpressure: res_ready=0 with S2 full holds both stages and drops every req_ready.
// Build option: TC_MUL_SCHED_ROUND_ROBIN_EN selects rotating-pointer arbitration; undefined gives fixed priority.
module tc_mul_scheduler #(
  parameter int NREQ  = 4,
  parameter int TAG_W = 8
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*15-1:0]      req_a,
  input  logic [NREQ*16-1:0]      req_b,
  input  logic [NREQ*TAG_W-1:0]   req_tag,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [29:0]             res_p,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic [TAG_W-1:0]        res_tag
);
  localparam int IDW = $clog2(NREQ);

  typedef struct packed {
    logic [14:0]      a;
    logic [15:0]      b;
    logic [IDW-1:0]   id;
    logic [TAG_W-1:0] tag;
  } op_t;

  op_t            gnt_dat;
  op_t            s1_dat;
  logic           s1_vld;
  logic           s2_vld;
  logic           advance;
  logic           accept;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  logic [29:0]    ext_a;
  logic [29:0]    ext_b;
  logic [29:0]    prod;

  // the whole pipe moves together whenever S2 is empty or being drained
  assign advance   = !s2_vld || res_ready;
  assign accept    = gnt_vld && advance;
  assign res_valid = s2_vld;

`ifdef TC_MUL_SCHED_ROUND_ROBIN_EN
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] rot;
  logic [IDW:0]    sum;

  // first valid requester at or above ptr, wrapping past NREQ-1 back to 0
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    rot     = NREQ'({req_valid, req_valid} >> ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_vld && rot[k]) begin
        gnt_vld = 1'b1;
        sum     = {1'b0, ptr} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        gnt_idx = sum[IDW-1:0];
      end
    end
  end

  // move the pointer just past the winner, but only when the grant is taken
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)      ptr <= '0;
    else if (accept) ptr <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
  end
`else
  // lowest-indexed valid requester wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_vld && req_valid[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
  end
`endif

  // steer the winner's operands into S1 and raise only the winner's ready
  always_comb begin
    gnt_dat   = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IDW'(k)) begin
        gnt_dat.a    = req_a[k*15 +: 15];
        gnt_dat.b    = req_b[k*16 +: 16];
        gnt_dat.tag  = req_tag[k*TAG_W +: TAG_W];
        req_ready[k] = accept && !ap_rst;
      end
    end
    gnt_dat.id = gnt_idx;
  end

  // S1: capture the granted request; a cycle with no grant loads a bubble
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else if (advance) begin
      s1_vld <= gnt_vld;
      if (gnt_vld) s1_dat <= gnt_dat;
    end
  end

  // sign-extend to 30 bits so the truncated product is the wrapped a*b
  assign ext_a = {{15{s1_dat.a[14]}}, s1_dat.a};
  assign ext_b = {{14{s1_dat.b[15]}}, s1_dat.b};
  assign prod  = ext_a * ext_b;

  // S2: register the product with its owner; holds while the consumer stalls
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s2_vld  <= 1'b0;
      res_p   <= '0;
      res_id  <= '0;
      res_tag <= '0;
    end else if (advance) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        res_p   <= prod;
        res_id  <= s1_dat.id;
        res_tag <= s1_dat.tag;
      end
    end
  end
endmodule
